pulse_cmd_queue: RTL and testbench
==================================

// Module: pulse_cmd_queue
// PURPOSE
//  Downstream of the pulse parameter register. On each cstrobe, captures the registered pulse
//  fields (phase, freq, amp, env_word, cfg) as one command word and queues it in a FIFO.
//  Each command is dispatched to one of N_DEST signal-generator element ports, chosen by cfg
//  dest bits, using a valid/ready handshake. Absorbs bursts of back-to-back pulse triggers
//  while an element is stalled; flags overflow.
// PARAMETERS
//  PHASE_WIDTH     17  phase offset field width
//  FREQ_WIDTH      9   frequency index width
//  AMP_WIDTH       16  amplitude width
//  ENV_WORD_WIDTH  24  envelope word width ({addr[23:12], len[11:0]})
//  CFG_WIDTH       4   cfg width; cfg[DEST_WIDTH-1:0]=dest, remaining MSBs=mode
//  DEST_WIDTH      2   dest field width; N_DEST = 2**DEST_WIDTH
//  DEPTH_LOG2      3   FIFO depth = 2**DEPTH_LOG2 entries
// PORTS
//  clk            in   1           system clock
//  reset          in   1           asynchronous, active-high reset
//  phase          in   PHASE_WIDTH registered phase offset
//  freq           in   FREQ_WIDTH  registered freq index
//  amp            in   AMP_WIDTH   registered amplitude
//  env_word       in   ENV_WORD_WIDTH registered envelope word
//  cfg            in   CFG_WIDTH   registered mode+dest
//  cstrobe        in   1           push request: fields valid this cycle
//  clear_err      in   1           clears sticky overflow flag
//  out_ready      in   N_DEST      per-element ready
//  out_valid      out  N_DEST      one-hot valid; bit = head entry's dest
//  out_phase      out  PHASE_WIDTH head entry phase (shared by all elements)
//  out_freq       out  FREQ_WIDTH  head entry freq
//  out_amp        out  AMP_WIDTH   head entry amp
//  out_env_word   out  ENV_WORD_WIDTH head entry envelope word
//  out_mode       out  CFG_WIDTH-DEST_WIDTH head entry mode bits
//  level          out  DEPTH_LOG2+1 current occupancy, 0..2**DEPTH_LOG2
//  overflow       out  1           sticky: a cstrobe was dropped
// BEHAVIOUR
//  - Reset (async assert, sync-released use): level=0, out_valid=0, overflow=0, all out_* data=0.
//    Reset mid-burst discards all entries; no handshake completes in the reset cycle.
//  - Push: rising clk with cstrobe=1 writes {cfg,env_word,amp,freq,phase} at wr_ptr when
//    level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
//    Otherwise, the command is dropped, overflow<=1, and the FIFO is unchanged.
//  - Pop: occurs when out_valid[dest_head] & out_ready[dest_head]. Ready on other bits is ignored.
//  - Head is registered, first-word-fall-through. A push into an empty queue at edge N gives
//    out_valid at edge N+1 (1-cycle latency). Back-to-back pops sustain 1 command/cycle.
//  - out_* data hold stable while out_valid!=0 and no pop; they are 0 when empty.
//  - Simultaneous push+pop: level unchanged. Empty+push+no pop: level 0->1.
//  - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Full/empty are derived from level.
//  - Head-of-line blocking is intended: a stalled dest blocks later entries for other
//    dests, preserving global pulse order.
//  - overflow clears on clear_err=1. If clear_err and a dropped push occur in the same
//    cycle, set wins (overflow=1).
//  - No arithmetic on fields: bit-exact pass-through. level is an unsigned up/down counter.
// STRUCTURE
//  - Shared package pulse_pkg: field widths, ENTRY_WIDTH = sum of fields (70 by default),
//    and field-slice localparams for packing/unpacking the entry.
//  - Sub-module sync_fifo_fwft (WIDTH, DEPTH_LOG2): storage, pointers, level, full/empty,
//    and registered head. pulse_cmd_queue adds packing, dest one-hot decode, pop select,
//    and overflow logic.
// TESTING
//  1 Reset, then cstrobe with cfg=4'b0110, amp=16'h1234 -> next cycle out_valid=4'b0100,
//    out_amp=16'h1234, out_mode=2'b01, level=1.
//  2 8 back-to-back cstrobes with out_ready=0, then a 9th -> level=8, overflow=1; then
//    out_ready=4'hF -> 8 pops on consecutive cycles in push order; level=0.
//  3 Full with head dest=3, push+pop in same cycle -> push accepted, overflow stays 0, level=8.
//  4 Head dest=1, out_ready=4'b1101 -> no pop for 10 cycles, data stable; set bit1 -> pop.
//  5 clear_err pulse after overflow -> overflow=0. clear_err coincident with a drop -> overflow=1.
//  6 Assert reset with level=5 mid-handshake -> out_valid=0, level=0 immediately (async);
//    after release, first new push appears with 1-cycle latency.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared widths and entry layout for the pulse command queue.
// Entry packing, LSB first: phase | freq | amp | env_word | cfg.
package pulse_pkg;

  localparam int PHASE_WIDTH    = 17;
  localparam int FREQ_WIDTH     = 9;
  localparam int AMP_WIDTH      = 16;
  localparam int ENV_WORD_WIDTH = 24;
  localparam int CFG_WIDTH      = 4;
  localparam int DEST_WIDTH     = 2;
  localparam int DEPTH_LOG2     = 3;

  localparam int N_DEST     = 2 ** DEST_WIDTH;
  localparam int MODE_WIDTH = CFG_WIDTH - DEST_WIDTH;

  localparam int ENTRY_WIDTH = PHASE_WIDTH + FREQ_WIDTH + AMP_WIDTH
                             + ENV_WORD_WIDTH + CFG_WIDTH;

  localparam int PHASE_LSB = 0;
  localparam int FREQ_LSB  = PHASE_LSB + PHASE_WIDTH;
  localparam int AMP_LSB   = FREQ_LSB + FREQ_WIDTH;
  localparam int ENV_LSB   = AMP_LSB + AMP_WIDTH;
  localparam int CFG_LSB   = ENV_LSB + ENV_WORD_WIDTH;
  localparam int DEST_LSB  = CFG_LSB;
  localparam int MODE_LSB  = CFG_LSB + DEST_WIDTH;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// The caller guarantees push only when not full (or popping) and pop only
// when not empty; the head register is zero whenever the FIFO is empty.
module sync_fifo_fwft #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_inc;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic [WIDTH-1:0]      head_nxt;

  assign empty      = (level == '0);
  assign full       = (level == LEVEL_FULL);
  assign rd_ptr_inc = rd_ptr + DEPTH_LOG2'(1);

  // Next occupancy and next head word; a lone remaining entry being popped
  // while a push arrives hands the pushed word straight to the head.
  always_comb begin
    level_nxt = level;
    head_nxt  = dout;
    case ({push, pop})
      2'b10:   level_nxt = level + LEVEL_ONE;
      2'b01:   level_nxt = level - LEVEL_ONE;
      default: level_nxt = level;
    endcase
    if (level_nxt == '0) begin
      head_nxt = '0;
    end else if (pop) begin
      head_nxt = (level == LEVEL_ONE) ? din : mem[rd_ptr_inc];
    end else if (empty && push) begin
      head_nxt = din;
    end
  end

  // Storage array; no reset needed since reads are qualified by level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered head word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      level <= level_nxt;
      dout  <= head_nxt;
    end
  end

endmodule

// File: rtl/pulse_cmd_queue.sv
// Queues pulse commands captured on cstrobe and dispatches them in order to
// the signal-generator element chosen by the head entry's dest bits.
// A stalled element blocks the whole queue so global pulse order is kept.
module pulse_cmd_queue
  import pulse_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PHASE_WIDTH-1:0]    phase,
  input  logic [FREQ_WIDTH-1:0]     freq,
  input  logic [AMP_WIDTH-1:0]      amp,
  input  logic [ENV_WORD_WIDTH-1:0] env_word,
  input  logic [CFG_WIDTH-1:0]      cfg,
  input  logic                      cstrobe,
  input  logic                      clear_err,
  input  logic [N_DEST-1:0]         out_ready,
  output logic [N_DEST-1:0]         out_valid,
  output logic [PHASE_WIDTH-1:0]    out_phase,
  output logic [FREQ_WIDTH-1:0]     out_freq,
  output logic [AMP_WIDTH-1:0]      out_amp,
  output logic [ENV_WORD_WIDTH-1:0] out_env_word,
  output logic [MODE_WIDTH-1:0]     out_mode,
  output logic [DEPTH_LOG2:0]       level,
  output logic                      overflow
);

  logic [ENTRY_WIDTH-1:0] entry_in;
  logic [ENTRY_WIDTH-1:0] head;
  logic [DEST_WIDTH-1:0]  dest_head;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   full;
  logic                   empty;

  assign entry_in  = {cfg, env_word, amp, freq, phase};
  assign dest_head = head[DEST_LSB +: DEST_WIDTH];

  assign out_valid = empty ? '0 : (N_DEST'(1) << dest_head);
  assign pop       = !empty && out_ready[dest_head];
  assign push      = cstrobe && (!full || pop);
  assign drop      = cstrobe && full && !pop;

  assign out_phase    = head[PHASE_LSB +: PHASE_WIDTH];
  assign out_freq     = head[FREQ_LSB  +: FREQ_WIDTH];
  assign out_amp      = head[AMP_LSB   +: AMP_WIDTH];
  assign out_env_word = head[ENV_LSB   +: ENV_WORD_WIDTH];
  assign out_mode     = head[MODE_LSB  +: MODE_WIDTH];

  sync_fifo_fwft #(
    .WIDTH      (ENTRY_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (entry_in),
    .pop   (pop),
    .dout  (head),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  // Sticky overflow; a drop in the same cycle as clear_err keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_err) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_pulse_cmd_queue.sv
// Directed self-checking bench for pulse_cmd_queue.
module tb_pulse_cmd_queue;

  logic        clk;
  logic        reset;
  logic [16:0] phase;
  logic [8:0]  freq;
  logic [15:0] amp;
  logic [23:0] env_word;
  logic [3:0]  cfg;
  logic        cstrobe;
  logic        clear_err;
  logic [3:0]  out_ready;
  logic [3:0]  out_valid;
  logic [16:0] out_phase;
  logic [8:0]  out_freq;
  logic [15:0] out_amp;
  logic [23:0] out_env_word;
  logic [1:0]  out_mode;
  logic [3:0]  level;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;

  pulse_cmd_queue dut (
    .clk          (clk),
    .reset        (reset),
    .phase        (phase),
    .freq         (freq),
    .amp          (amp),
    .env_word     (env_word),
    .cfg          (cfg),
    .cstrobe      (cstrobe),
    .clear_err    (clear_err),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_phase    (out_phase),
    .out_freq     (out_freq),
    .out_amp      (out_amp),
    .out_env_word (out_env_word),
    .out_mode     (out_mode),
    .level        (level),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] exp_phase(input int id);
    return 17'(17'h10000 + id * 3);
  endfunction
  function automatic logic [8:0] exp_freq(input int id);
    return 9'(9'h100 + id);
  endfunction
  function automatic logic [15:0] exp_amp(input int id);
    return 16'(16'hA000 + id * 17);
  endfunction
  function automatic logic [23:0] exp_env(input int id);
    return 24'(24'hABC000 + id);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int id, input logic [3:0] c);
    phase    = exp_phase(id);
    freq     = exp_freq(id);
    amp      = exp_amp(id);
    env_word = exp_env(id);
    cfg      = c;
    cstrobe  = 1'b1;
  endtask

  task automatic drain();
    out_ready = 4'hF;
    cstrobe   = 1'b0;
    for (int i = 0; i < 20 && level != 4'd0; i++) tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    out_ready = 4'h0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (out_valid !== 4'b0 || level !== 4'd0 || overflow !== 1'b0 || out_amp !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b level=%0d ovf=%b amp=%h, want 0000/0/0/0000",
               out_valid, level, overflow, out_amp);
    end
  endtask

  task automatic test_first_push();
    set_cmd(1, 4'b0110);
    amp = 16'h1234;
    tick();
    cstrobe = 1'b0;
    tests_run++;
    if (out_valid !== 4'b0100 || out_amp !== 16'h1234 || out_mode !== 2'b01 || level !== 4'd1) begin
      tests_failed++;
      $display("FAIL first_push: valid=%b amp=%h mode=%b level=%0d, want 0100/1234/01/1",
               out_valid, out_amp, out_mode, level);
    end
    tests_run++;
    if (out_phase !== exp_phase(1) || out_freq !== exp_freq(1) || out_env_word !== exp_env(1)) begin
      tests_failed++;
      $display("FAIL first_fields: phase=%h freq=%h env=%h, want %h/%h/%h",
               out_phase, out_freq, out_env_word, exp_phase(1), exp_freq(1), exp_env(1));
    end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    tests_run++;
    if (out_valid !== 4'b0 || level !== 4'd0 || out_amp !== 16'h0 || out_phase !== 17'h0) begin
      tests_failed++;
      $display("FAIL first_pop_empty: valid=%b level=%0d amp=%h phase=%h, want 0000/0/0/0",
               out_valid, level, out_amp, out_phase);
    end
  endtask

  task automatic test_overflow_drain();
    out_ready = 4'h0;
    for (int i = 0; i < 8; i++) begin
      set_cmd(10 + i, {2'(i >> 2), 2'(i)});
      tick();
    end
    tests_run++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_8: level=%0d ovf=%b, want 8/0", level, overflow);
    end
    set_cmd(99, 4'b0000);
    tick();
    cstrobe = 1'b0;
    tests_run++;
    if (level !== 4'd8 || overflow !== 1'b1 || out_amp !== exp_amp(10)) begin
      tests_failed++;
      $display("FAIL ninth_dropped: level=%0d ovf=%b amp=%h, want 8/1/%h",
               level, overflow, out_amp, exp_amp(10));
    end
    out_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (out_valid !== 4'(1 << (i % 4)) || out_amp !== exp_amp(10 + i) ||
          out_mode !== 2'(i >> 2) || level !== 4'(8 - i)) begin
        tests_failed++;
        $display("FAIL drain_order[%0d]: valid=%b amp=%h mode=%b level=%0d, want %b/%h/%b/%0d",
                 i, out_valid, out_amp, out_mode, level, 4'(1 << (i % 4)), exp_amp(10 + i),
                 2'(i >> 2), 8 - i);
      end
      tick();
    end
    tests_run++;
    if (level !== 4'd0 || out_valid !== 4'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: level=%0d valid=%b, want 0/0000", level, out_valid);
    end
    out_ready = 4'h0;
  endtask

  task automatic test_clear_err();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_err: ovf=%b, want 0", overflow);
    end
    for (int i = 0; i < 8; i++) begin
      set_cmd(30 + i, 4'b0000);
      tick();
    end
    set_cmd(39, 4'b0000);
    clear_err = 1'b1;
    tick();
    cstrobe   = 1'b0;
    clear_err = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || level !== 4'd8) begin
      tests_failed++;
      $display("FAIL clear_vs_drop: ovf=%b level=%0d, want 1/8", overflow, level);
    end
    drain();
  endtask

  task automatic test_full_push_pop();
    set_cmd(40, 4'b1011);
    tick();
    for (int i = 1; i < 8; i++) begin
      set_cmd(40 + i, 4'(i % 3));
      tick();
    end
    cstrobe = 1'b0;
    tests_run++;
    if (level !== 4'd8 || out_valid !== 4'b1000 || out_mode !== 2'b10) begin
      tests_failed++;
      $display("FAIL full_head: level=%0d valid=%b mode=%b, want 8/1000/10",
               level, out_valid, out_mode);
    end
    set_cmd(48, 4'b0001);
    out_ready = 4'b1000;
    tick();
    cstrobe   = 1'b0;
    out_ready = 4'b0000;
    tests_run++;
    if (level !== 4'd8 || overflow !== 1'b0 || out_amp !== exp_amp(41) || out_valid !== 4'b0010) begin
      tests_failed++;
      $display("FAIL full_push_pop: level=%0d ovf=%b amp=%h valid=%b, want 8/0/%h/0010",
               level, overflow, out_amp, out_valid, exp_amp(41));
    end
    out_ready = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      tests_run++;
      if (out_amp !== exp_amp(40 + i) || out_phase !== exp_phase(40 + i)) begin
        tests_failed++;
        $display("FAIL full_wrap_order[%0d]: amp=%h phase=%h, want %h/%h",
                 i, out_amp, out_phase, exp_amp(40 + i), exp_phase(40 + i));
      end
      tick();
    end
    drain();
  endtask

  task automatic test_hol_block();
    logic [15:0] held_amp;
    set_cmd(60, 4'b1101);
    tick();
    set_cmd(61, 4'b0000);
    tick();
    cstrobe   = 1'b0;
    out_ready = 4'b1101;
    held_amp  = exp_amp(60);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (out_valid !== 4'b0010 || out_amp !== held_amp || out_mode !== 2'b11 || level !== 4'd2) begin
        tests_failed++;
        $display("FAIL hol_stall[%0d]: valid=%b amp=%h mode=%b level=%0d, want 0010/%h/11/2",
                 i, out_valid, out_amp, out_mode, level, held_amp);
      end
      tick();
    end
    out_ready = 4'b0010;
    tick();
    out_ready = 4'b0000;
    tests_run++;
    if (level !== 4'd1 || out_valid !== 4'b0001 || out_amp !== exp_amp(61)) begin
      tests_failed++;
      $display("FAIL hol_release: level=%0d valid=%b amp=%h, want 1/0001/%h",
               level, out_valid, out_amp, exp_amp(61));
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      set_cmd(70 + i, 4'b0001);
      tick();
    end
    cstrobe   = 1'b0;
    out_ready = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 4'b0 || level !== 4'd0 || out_amp !== 16'h0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b level=%0d amp=%h, want 0000/0/0000",
               out_valid, level, out_amp);
    end
    out_ready = 4'h0;
    tick();
    reset = 1'b0;
    set_cmd(80, 4'b0010);
    amp = 16'hBEEF;
    tick();
    cstrobe = 1'b0;
    tests_run++;
    if (out_valid !== 4'b0100 || out_amp !== 16'hBEEF || level !== 4'd1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_push: valid=%b amp=%h level=%0d ovf=%b, want 0100/beef/1/0",
               out_valid, out_amp, level, overflow);
    end
  endtask

  initial begin
    reset     = 1'b1;
    phase     = '0;
    freq      = '0;
    amp       = '0;
    env_word  = '0;
    cfg       = '0;
    cstrobe   = 1'b0;
    clear_err = 1'b0;
    out_ready = '0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_reset();
    test_first_push();
    test_overflow_drain();
    test_clear_err();
    test_full_push_pop();
    test_hol_block();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
